time_set_ctrl: RTL and testbench

//  Sequences the six-digit clock display and lets the user set the time.

---
 rtl/time_set_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Display sequencer and time-set controller for a six-digit DS1302 clock:
// shows live RTC time, edits hr/min/sec with a blinking field, and commits one RTC write.
module time_set_ctrl #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rtc_hr,
    input  logic [7:0] rtc_min,
    input  logic [7:0] rtc_sec,
    input  logic       rtc_valid,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [7:0] disp_hr,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec,
    output logic [5:0] blank,
    output logic       editing,
    output logic       wr_req,
    output logic [7:0] wr_hr,
    output logic [7:0] wr_min,
    output logic [7:0] wr_sec,
    input  logic       wr_ack
);
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {RUN, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    hr_reg, hr_next, min_reg, min_next, sec_reg, sec_next;
    logic [7:0]    wr_hr_reg, wr_hr_next, wr_min_reg, wr_min_next, wr_sec_reg, wr_sec_next;
    logic          wr_req_reg, wr_req_next;
    logic [5:0]    blank_reg, blank_next;
    logic          editing_reg, editing_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          phase_reg, phase_next;
    logic          step_up, step_dn;

    // Out-of-range values (e.g. a corrupt RTC read) snap back into range on the first step.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v >= max)
            return 8'h00;
        if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00 || v > max)
            return max;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        if (v[3:0] > 4'd9)
            return {v[7:4], 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= RUN;
            hr_reg      <= 8'h00;
            min_reg     <= 8'h00;
            sec_reg     <= 8'h00;
            wr_hr_reg   <= 8'h00;
            wr_min_reg  <= 8'h00;
            wr_sec_reg  <= 8'h00;
            wr_req_reg  <= 1'b0;
            blank_reg   <= 6'b0;
            editing_reg <= 1'b0;
            cnt_reg     <= '0;
            phase_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hr_reg      <= hr_next;
            min_reg     <= min_next;
            sec_reg     <= sec_next;
            wr_hr_reg   <= wr_hr_next;
            wr_min_reg  <= wr_min_next;
            wr_sec_reg  <= wr_sec_next;
            wr_req_reg  <= wr_req_next;
            blank_reg   <= blank_next;
            editing_reg <= editing_next;
            cnt_reg     <= cnt_next;
            phase_reg   <= phase_next;
        end
    end

    // The display registers double as the edit values, so entering edit starts from what is shown.
    always_comb begin
        state_next  = state_reg;
        hr_next     = hr_reg;
        min_next    = min_reg;
        sec_next    = sec_reg;
        wr_hr_next  = wr_hr_reg;
        wr_min_next = wr_min_reg;
        wr_sec_next = wr_sec_reg;
        wr_req_next = wr_req_reg;
        cnt_next    = cnt_reg;
        phase_next  = phase_reg;
        blank_next  = 6'b0;
        step_up     = btn_inc & ~btn_dec;
        step_dn     = btn_dec & ~btn_inc;

        case (state_reg)
            RUN: begin
                if (btn_mode) begin
                    state_next = EDIT_HR;
                end else if (rtc_valid) begin
                    hr_next  = {2'b00, rtc_hr[5:0]};
                    min_next = {1'b0, rtc_min[6:0]};
                    sec_next = {1'b0, rtc_sec[6:0]};
                end
            end
            EDIT_HR: begin
                if (btn_mode)     state_next = EDIT_MIN;
                else if (step_up) hr_next = bcd_inc(hr_reg, 8'h23);
                else if (step_dn) hr_next = bcd_dec(hr_reg, 8'h23);
            end
            EDIT_MIN: begin
                if (btn_mode)     state_next = EDIT_SEC;
                else if (step_up) min_next = bcd_inc(min_reg, 8'h59);
                else if (step_dn) min_next = bcd_dec(min_reg, 8'h59);
            end
            EDIT_SEC: begin
                if (btn_mode) begin
                    state_next  = COMMIT;
                    wr_hr_next  = hr_reg;
                    wr_min_next = min_reg;
                    wr_sec_next = sec_reg;
                    wr_req_next = 1'b1;
                end else if (step_up) begin
                    sec_next = bcd_inc(sec_reg, 8'h59);
                end else if (step_dn) begin
                    sec_next = bcd_dec(sec_reg, 8'h59);
                end
            end
            COMMIT: begin
                if (wr_ack) begin
                    wr_req_next = 1'b0;
                    state_next  = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        // Every fresh edit field starts visible; blank follows the registered phase.
        if (state_next inside {EDIT_HR, EDIT_MIN, EDIT_SEC}) begin
            if (state_next != state_reg) begin
                cnt_next   = '0;
                phase_next = 1'b0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_next   = '0;
                phase_next = ~phase_reg;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end else begin
            cnt_next   = '0;
            phase_next = 1'b0;
        end

        if (phase_next) begin
            case (state_next)
                EDIT_HR:  blank_next = 6'b110000;
                EDIT_MIN: blank_next = 6'b001100;
                EDIT_SEC: blank_next = 6'b000011;
                default:  blank_next = 6'b0;
            endcase
        end
        editing_next = (state_next != RUN);
    end

    assign disp_hr  = hr_reg;
    assign disp_min = min_reg;
    assign disp_sec = sec_reg;
    assign blank    = blank_reg;
    assign editing  = editing_reg;
    assign wr_req   = wr_req_reg;
    assign wr_hr    = wr_hr_reg;
    assign wr_min   = wr_min_reg;
    assign wr_sec   = wr_sec_reg;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expectations are queued with each stimulus cycle
// and compared one cycle later against the registered outputs.
module tb_time_set_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rtc_hr = 8'h00, rtc_min = 8'h00, rtc_sec = 8'h00;
    logic       rtc_valid = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic       wr_ack = 1'b0;
    logic [7:0] disp_hr, disp_min, disp_sec, wr_hr, wr_min, wr_sec;
    logic [5:0] blank;
    logic       editing, wr_req;

    int checks = 0;
    int failures = 0;

    localparam int S_DISP = 0, S_BLANK = 1, S_EDIT = 2, S_WRREQ = 3, S_WR = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [23:0] val;
    } exp_t;
    exp_t sb_q[$];

    time_set_ctrl #(.CLK_HZ(16), .BLINK_HZ(2)) dut (
        .clk(clk), .rst(rst),
        .rtc_hr(rtc_hr), .rtc_min(rtc_min), .rtc_sec(rtc_sec), .rtc_valid(rtc_valid),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .disp_hr(disp_hr), .disp_min(disp_min), .disp_sec(disp_sec),
        .blank(blank), .editing(editing),
        .wr_req(wr_req), .wr_hr(wr_hr), .wr_min(wr_min), .wr_sec(wr_sec),
        .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] hms(input int h, input int m, input int s);
        return {bcd(h), bcd(m), bcd(s)};
    endfunction

    function automatic logic [23:0] obs(input int sel);
        case (sel)
            S_DISP:  return {disp_hr, disp_min, disp_sec};
            S_BLANK: return {18'd0, blank};
            S_EDIT:  return {23'd0, editing};
            S_WRREQ: return {23'd0, wr_req};
            S_WR:    return {wr_hr, wr_min, wr_sec};
            default: return 24'd0;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic exp_push(input string tag, input int sel, input logic [23:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, obs(e.sel), e.val);
        end
    endtask

    // One clock of stimulus; queued expectations describe the outputs after this edge.
    task automatic step(input bit m, input bit i, input bit d, input bit v, input bit a);
        btn_mode  = m;
        btn_inc   = i;
        btn_dec   = d;
        rtc_valid = v;
        wr_ack    = a;
        @(posedge clk);
        #1;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        btn_dec   = 1'b0;
        rtc_valid = 1'b0;
        wr_ack    = 1'b0;
        drain();
    endtask

    task automatic load_rtc(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        rtc_hr  = h;
        rtc_min = m;
        rtc_sec = s;
    endtask

    initial begin
        // Reset state
        exp_push("rst_disp", S_DISP, 24'h0);
        exp_push("rst_blank", S_BLANK, 24'h0);
        exp_push("rst_edit", S_EDIT, 24'h0);
        exp_push("rst_wrreq", S_WRREQ, 24'h0);
        exp_push("rst_wr", S_WR, 24'h0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;

        // Live time, masking hour bits 7:6 and CH
        load_rtc(8'h13, 8'h45, 8'hB2);
        exp_push("run_disp", S_DISP, hms(13, 45, 32));
        exp_push("run_blank", S_BLANK, 24'h0);
        exp_push("run_edit", S_EDIT, 24'h0);
        step(0, 0, 0, 1, 0);

        // Wraps from 23:59:58
        load_rtc(8'h23, 8'h59, 8'h58);
        exp_push("load_235958", S_DISP, hms(23, 59, 58));
        step(0, 0, 0, 1, 0);
        exp_push("enter_edit", S_EDIT, 24'h1);
        exp_push("enter_disp", S_DISP, hms(23, 59, 58));
        step(1, 0, 0, 0, 0);
        exp_push("hr_wrap_up", S_DISP, hms(0, 59, 58));
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        exp_push("min_wrap_up", S_DISP, hms(0, 0, 58));
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 59; k++) begin
            exp_push($sformatf("sec_dec_%0d", k), S_DISP, hms(0, 0, (58 - k + 60) % 60));
            step(0, 0, 1, 0, 0);
        end
        exp_push("c1_wrreq", S_WRREQ, 24'h1);
        exp_push("c1_wr", S_WR, hms(0, 0, 59));
        step(1, 0, 0, 0, 0);
        exp_push("c1_ack_wrreq", S_WRREQ, 24'h0);
        exp_push("c1_ack_edit", S_EDIT, 24'h0);
        exp_push("c1_disp", S_DISP, hms(0, 0, 59));
        step(0, 0, 0, 0, 1);

        // Blink pattern with BLINK_DIV = 4
        step(1, 0, 0, 0, 0);
        exp_push("min_entry_blank", S_BLANK, 24'h0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            exp_push($sformatf("min_blink_%0d", i), S_BLANK,
                     (((i + 1) / 4) % 2 == 1) ? 24'h0C : 24'h0);
            step(0, 0, 0, 0, 0);
        end
        exp_push("sec_entry_blank", S_BLANK, 24'h0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            exp_push($sformatf("sec_blink_%0d", i), S_BLANK, (i == 3) ? 24'h03 : 24'h0);
            step(0, 0, 0, 0, 0);
        end
        exp_push("c2_blank", S_BLANK, 24'h0);
        exp_push("c2_wrreq", S_WRREQ, 24'h1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // Hour underflow, minute underflow, ack in first COMMIT cycle
        load_rtc(8'h00, 8'h00, 8'h00);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        exp_push("hr_wrap_dn", S_DISP, hms(23, 0, 0));
        step(0, 0, 1, 0, 0);
        exp_push("hr_back_up", S_DISP, hms(0, 0, 0));
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        exp_push("min_wrap_dn", S_DISP, hms(0, 59, 0));
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        exp_push("c3_wr", S_WR, hms(0, 59, 0));
        step(1, 0, 0, 0, 0);
        exp_push("c3_first_ack", S_WRREQ, 24'h0);
        exp_push("c3_edit", S_EDIT, 24'h0);
        step(0, 0, 0, 0, 1);

        // Edit to 07:08:09 and hold the request
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            exp_push($sformatf("hr_inc_%0d", i), S_DISP, hms(i, 0, 0));
            step(0, 1, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            exp_push($sformatf("min_inc_%0d", i), S_DISP, hms(7, i, 0));
            step(0, 1, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            exp_push($sformatf("sec_inc_%0d", i), S_DISP, hms(7, 8, i));
            step(0, 1, 0, 0, 0);
        end
        exp_push("c4_wrreq", S_WRREQ, 24'h1);
        exp_push("c4_wr", S_WR, hms(7, 8, 9));
        exp_push("c4_edit", S_EDIT, 24'h1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            exp_push($sformatf("hold_wrreq_%0d", i), S_WRREQ, 24'h1);
            exp_push($sformatf("hold_wr_%0d", i), S_WR, hms(7, 8, 9));
            exp_push($sformatf("hold_disp_%0d", i), S_DISP, hms(7, 8, 9));
            step(i == 4, i == 5, i == 6, 0, 0);
        end
        exp_push("c4_ack_wrreq", S_WRREQ, 24'h0);
        exp_push("c4_ack_edit", S_EDIT, 24'h0);
        exp_push("c4_disp", S_DISP, hms(7, 8, 9));
        step(0, 0, 0, 0, 1);
        exp_push("stray_ack_edit", S_EDIT, 24'h0);
        exp_push("stray_ack_wrreq", S_WRREQ, 24'h0);
        step(0, 0, 0, 0, 1);

        // Same-cycle conflicts
        step(1, 0, 0, 0, 0);
        exp_push("inc_dec_same", S_DISP, hms(7, 8, 9));
        step(0, 1, 1, 0, 0);
        load_rtc(8'h11, 8'h22, 8'h33);
        exp_push("rtc_in_edit", S_DISP, hms(7, 8, 9));
        step(0, 0, 0, 1, 0);
        exp_push("mode_inc_disp", S_DISP, hms(7, 8, 9));
        step(1, 1, 0, 0, 0);
        exp_push("advanced_to_min", S_DISP, hms(7, 9, 9));
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        exp_push("c5_wrreq", S_WRREQ, 24'h1);
        step(1, 0, 0, 0, 0);

        // Async reset while a write is pending
        #2;
        rst = 1'b1;
        #1;
        exp_push("async_wrreq", S_WRREQ, 24'h0);
        exp_push("async_edit", S_EDIT, 24'h0);
        drain();
        #3;
        rst = 1'b0;
        exp_push("post_rst_disp", S_DISP, 24'h0);
        exp_push("post_rst_wrreq", S_WRREQ, 24'h0);
        step(0, 0, 0, 0, 1);
        load_rtc(8'h12, 8'h34, 8'h56);
        exp_push("post_rst_run", S_DISP, hms(12, 34, 56));
        exp_push("post_rst_edit", S_EDIT, 24'h0);
        step(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
